// File: rtl/carry_select_adder_if.sv
// Operand/result bundle for the 16-bit carry-select adder.
interface carry_select_adder_if;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        carry;
    logic [2:0]  inc;

    // Operand source drives a/b/cin and observes the registered results.
    modport master (
        output a,
        output b,
        output cin,
        input  sum,
        input  carry,
        input  inc
    );

    // Adder consumes operands and produces registered results.
    modport slave (
        input  a,
        input  b,
        input  cin,
        output sum,
        output carry,
        output inc
    );
endinterface

// File: rtl/carry_select_adder.sv
// 16-bit carry-select adder: ripple nibble B0, speculative nibble pairs for
// B1..B3 selected by the preceding block carry, results registered once.
// Ports stay scalar and in fixed order so legacy positional instances of the
// first six ports keep working; carry_select_adder_if bundles them for users.
module carry_select_adder (
    output logic [15:0] sum,
    output logic        carry,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [2:0]  inc,
    input  logic        clk,
    input  logic        rst
);

    localparam int unsigned WIDTH = 16;
    localparam int unsigned BLK   = 4;
    localparam int unsigned NBLK  = WIDTH / BLK;

    // 4-bit ripple-carry adder built from a chain of full adders; {cout, sum}.
    function automatic logic [BLK:0] ripple4(
        input logic [BLK-1:0] x,
        input logic [BLK-1:0] y,
        input logic           c
    );
        logic [BLK:0]   cy;
        logic [BLK-1:0] s;
        cy[0] = c;
        for (int i = 0; i < int'(BLK); i++) begin
            s[i]    = x[i] ^ y[i] ^ cy[i];
            cy[i+1] = (x[i] & y[i]) | (cy[i] & (x[i] ^ y[i]));
        end
        return {cy[BLK], s};
    endfunction

    logic [BLK:0]      blk0;
    logic [BLK:0]      spec0 [NBLK];
    logic [BLK:0]      spec1 [NBLK];
    logic [WIDTH-1:0]  sum_c;
    logic [NBLK-1:0]   blk_cout_c;

    // B0 ripples directly from cin.
    assign blk0 = ripple4(a[BLK-1:0], b[BLK-1:0], cin);

    // Index 0 of the speculative arrays is unused; tie it off.
    assign spec0[0] = '0;
    assign spec1[0] = '0;

    // Upper blocks compute both carry-in hypotheses in parallel.
    for (genvar k = 1; k < int'(NBLK); k++) begin : g_spec
        assign spec0[k] = ripple4(a[k*BLK +: BLK], b[k*BLK +: BLK], 1'b0);
        assign spec1[k] = ripple4(a[k*BLK +: BLK], b[k*BLK +: BLK], 1'b1);
    end

    // Carry-select mux chain: each block's result picked by the previous carry-out.
    always_comb begin
        sum_c         = '0;
        blk_cout_c    = '0;
        sum_c[BLK-1:0] = blk0[BLK-1:0];
        blk_cout_c[0]  = blk0[BLK];
        for (int k = 1; k < int'(NBLK); k++) begin
            if (blk_cout_c[k-1]) begin
                sum_c[k*BLK +: BLK] = spec1[k][BLK-1:0];
                blk_cout_c[k]       = spec1[k][BLK];
            end else begin
                sum_c[k*BLK +: BLK] = spec0[k][BLK-1:0];
                blk_cout_c[k]       = spec0[k][BLK];
            end
        end
    end

    // Output registers, cleared asynchronously and loaded every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum   <= '0;
            carry <= 1'b0;
            inc   <= '0;
        end else begin
            sum   <= sum_c;
            carry <= blk_cout_c[NBLK-1];
            inc   <= blk_cout_c[NBLK-2:0];
        end
    end

endmodule

// File: tb/tb_carry_select_adder.sv
// Directed and random checks for carry_select_adder.
module tb_carry_select_adder;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    carry_select_adder_if bus ();

    carry_select_adder dut (
        .sum   (bus.sum),
        .carry (bus.carry),
        .a     (bus.a),
        .b     (bus.b),
        .cin   (bus.cin),
        .inc   (bus.inc),
        .clk   (clk),
        .rst   (rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it differs.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive operands on the falling edge, check results just after the next rising edge.
    task automatic apply(input string tag, input logic [15:0] va, input logic [15:0] vb,
                         input logic vc, input logic [15:0] es, input logic ec,
                         input logic [2:0] ei);
        @(negedge clk);
        bus.a   = va;
        bus.b   = vb;
        bus.cin = vc;
        @(posedge clk);
        #1;
        check({tag, "_sum"},   32'(bus.sum),   32'(es));
        check({tag, "_carry"}, 32'(bus.carry), 32'(ec));
        check({tag, "_inc"},   32'(bus.inc),   32'(ei));
    endtask

    // Independent reference: full 17-bit add, and boundary carries from masked adds.
    task automatic apply_ref(input string tag, input logic [15:0] va, input logic [15:0] vb,
                             input logic vc);
        logic [16:0] full;
        logic [16:0] part;
        logic [16:0] mask;
        logic [2:0]  ei;
        full = 17'(va) + 17'(vb) + 17'(vc);
        for (int k = 0; k < 3; k++) begin
            mask  = (17'd1 << (4 * (k + 1))) - 17'd1;
            part  = (17'(va) & mask) + (17'(vb) & mask) + 17'(vc);
            ei[k] = part[4 * (k + 1)];
        end
        apply(tag, va, vb, vc, full[15:0], full[16], ei);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        bus.a   = 16'hFFFF;
        bus.b   = 16'hFFFF;
        bus.cin = 1'b1;

        // Reset state before any clock edge, and held across edges.
        #2;
        check("rst_sum",   32'(bus.sum),   32'h0);
        check("rst_carry", 32'(bus.carry), 32'h0);
        check("rst_inc",   32'(bus.inc),   32'h0);
        @(posedge clk);
        #1;
        check("rst_hold_sum", 32'(bus.sum), 32'h0);
        check("rst_hold_inc", 32'(bus.inc), 32'h0);

        @(negedge clk);
        rst = 1'b0;

        // Directed vectors.
        apply("v025", 16'hA862, 16'h3FFF, 1'b0, 16'hE861, 1'b0, 3'b111);
        apply("v026", 16'hF03F, 16'hFFC0, 1'b0, 16'hEFFF, 1'b1, 3'b000);
        apply("v027", 16'hAAE2, 16'h151D, 1'b1, 16'hC000, 1'b0, 3'b111);
        apply("v028", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 3'b111);
        apply("v029a", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 3'b111);
        apply("v029b", 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 3'b000);
        apply("blk1", 16'h00F0, 16'h0010, 1'b0, 16'h0100, 1'b0, 3'b010);
        apply("blk2", 16'h0F00, 16'h0100, 1'b0, 16'h1000, 1'b0, 3'b100);
        apply("mid", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 3'b000);

        // Asynchronous reset between edges while outputs are nonzero.
        apply("pre_rst", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 3'b111);
        #3;
        rst = 1'b1;
        #1;
        check("async_sum",   32'(bus.sum),   32'h0);
        check("async_carry", 32'(bus.carry), 32'h0);
        check("async_inc",   32'(bus.inc),   32'h0);
        @(negedge clk);
        rst = 1'b0;

        // First edge after release takes the operands present at that edge.
        apply("post_rst", 16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 3'b000);

        // Random operands, one per cycle.
        for (int n = 0; n < 10000; n++) begin
            apply_ref("rnd", 16'($urandom), 16'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
